// File: rtl/seg_display_scanner_pkg.sv
// Shared definitions for the multiplexed 7-segment display scanner.
//   - Segment vectors are {a,b,c,d,e,f,g}, active low: seg[6]=a ... seg[0]=g.
//   - SEG_OFF / SEG_DASH constants, digit pattern table 0-9, decode helper.
//   - Slot state type used by the scan timer.
package seg_display_scanner_pkg;

   localparam logic [6:0] SEG_OFF  = 7'b1111111;
   localparam logic [6:0] SEG_DASH = 7'b1111110;

   localparam logic [6:0] DIGIT_PATTERNS [0:9] = '{
      7'b0000001,   // 0
      7'b1001111,   // 1
      7'b0010010,   // 2
      7'b0000110,   // 3
      7'b1001100,   // 4
      7'b0100100,   // 5
      7'b0100000,   // 6
      7'b0001111,   // 7
      7'b0000000,   // 8
      7'b0001100    // 9
   };

   typedef enum logic {
      SLOT_GUARD,
      SLOT_SHOW
   } slot_state_t;

   // Non-BCD codes (A-F) render as a dash.
   function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
      logic [6:0] pattern;
      pattern = SEG_DASH;
      if (bcd <= 4'd9) pattern = DIGIT_PATTERNS[bcd];
      return pattern;
   endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot timer for the display scanner.
//   clk, rst_n  : clock, asynchronous active-low reset
//   en          : scan enable; low synchronously clears cnt/idx
//   idx         : digit slot currently being scanned
//   in_guard    : high during the leading guard cycles of a slot
//   frame_load  : high on the cycle cnt==0, idx==0 while enabled
module seg_scan_timer
   import seg_display_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned GUARD_CYCLES = 1000,
   parameter int unsigned IDX_W        = $clog2(NUM_DIGITS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [IDX_W-1:0] idx,
   output logic             in_guard,
   output logic             frame_load
);

   localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   logic [CNT_W-1:0] cnt;
   slot_state_t      state, state_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         idx <= '0;
      end else if (!en) begin
         cnt <= '0;
         idx <= '0;
      end else if (cnt == CNT_LAST) begin
         cnt <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // State tracks cnt < GUARD_CYCLES one step ahead, so it stays aligned
   // with cnt without a wide comparator on the output path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= SLOT_GUARD;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (!en || cnt == CNT_LAST) state_next = SLOT_GUARD;
      else if (cnt == GUARD_LAST) state_next = SLOT_SHOW;
   end

   assign in_guard   = (state == SLOT_GUARD);
   assign frame_load = en && (cnt == '0) && (idx == '0);

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed common-anode 7-segment display driver.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : scan enable; low = display dark, scan held at slot 0
//   digits_bcd   : packed BCD, [3:0] = digit 0 (rightmost)
//   blank_mask   : 1 = force digit dark
//   dp_mask      : 1 = light that digit's decimal point
//   lz_blank     : 1 = suppress leading zeros (digit 0 always shown)
//   an           : anode enables, active low
//   seg          : segments {a..g}, active low
//   dp           : decimal point, active low
//   frame_start  : one-cycle pulse after each snapshot load
module seg_display_scanner
   import seg_display_scanner_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned DWELL_CYCLES = 100000,
   parameter int unsigned GUARD_CYCLES = 1000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic [4*NUM_DIGITS-1:0] digits_bcd,
   input  logic [NUM_DIGITS-1:0]   blank_mask,
   input  logic [NUM_DIGITS-1:0]   dp_mask,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    frame_start
);

   localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

   logic [IDX_W-1:0]      idx;
   logic                  in_guard;
   logic                  frame_load;

   logic [3:0]            snap_digits [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] snap_dp;
   logic [NUM_DIGITS-1:0] snap_blank;

   logic [NUM_DIGITS-1:0] lz_mask;
   logic                  zero_run;
   logic [NUM_DIGITS-1:0] an_d;
   logic [6:0]            seg_d;
   logic                  dp_d;

   seg_scan_timer #(
      .NUM_DIGITS   (NUM_DIGITS),
      .DWELL_CYCLES (DWELL_CYCLES),
      .GUARD_CYCLES (GUARD_CYCLES),
      .IDX_W        (IDX_W)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .idx        (idx),
      .in_guard   (in_guard),
      .frame_load (frame_load)
   );

   // Walk from the most significant digit down, blanking zeros until the
   // first nonzero digit; digit 0 is never part of the walk.
   always_comb begin
      lz_mask  = '0;
      zero_run = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
         if (zero_run && digits_bcd[4*(NUM_DIGITS-1-k) +: 4] == 4'd0)
            lz_mask[NUM_DIGITS-1-k] = 1'b1;
         else
            zero_run = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++) snap_digits[i] <= '0;
         snap_dp    <= '0;
         snap_blank <= '0;
      end else if (frame_load) begin
         for (int unsigned i = 0; i < NUM_DIGITS; i++)
            snap_digits[i] <= digits_bcd[4*i +: 4];
         snap_dp    <= dp_mask;
         snap_blank <= blank_mask | (lz_blank ? lz_mask : '0);
      end
   end

   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (en && !in_guard && !snap_blank[idx]) begin
         an_d[idx] = 1'b0;
         seg_d     = seg_decode(snap_digits[idx]);
         dp_d      = ~snap_dp[idx];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an          <= '1;
         seg         <= SEG_OFF;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         an          <= an_d;
         seg         <= seg_d;
         dp          <= dp_d;
         frame_start <= frame_load;
      end
   end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Self-checking bench for seg_display_scanner (4 digits, dwell 8, guard 2).
// A cycle model pushes the expected registered outputs before each clock
// edge; they are popped and compared one time unit after the edge.
module tb_seg_display_scanner;

   localparam int ND = 4;
   localparam int DW = 8;
   localparam int GD = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [4*ND-1:0] digits_bcd;
   logic [ND-1:0] blank_mask;
   logic [ND-1:0] dp_mask;
   logic          lz_blank;
   logic [ND-1:0] an;
   logic [6:0]    seg;
   logic          dp;
   logic          frame_start;

   always #5 clk = ~clk;

   seg_display_scanner #(
      .NUM_DIGITS   (ND),
      .DWELL_CYCLES (DW),
      .GUARD_CYCLES (GD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .digits_bcd  (digits_bcd),
      .blank_mask  (blank_mask),
      .dp_mask     (dp_mask),
      .lz_blank    (lz_blank),
      .an          (an),
      .seg         (seg),
      .dp          (dp),
      .frame_start (frame_start)
   );

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fs;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;

   int m_cnt, m_idx, o_cnt, o_idx;
   logic [3:0]    m_dig [ND];
   logic [ND-1:0] m_dp;
   logic [ND-1:0] m_blank;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] tb_decode(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0000001;
         4'd1: return 7'b1001111;
         4'd2: return 7'b0010010;
         4'd3: return 7'b0000110;
         4'd4: return 7'b1001100;
         4'd5: return 7'b0100100;
         4'd6: return 7'b0100000;
         4'd7: return 7'b0001111;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0001100;
         default: return 7'b1111110;
      endcase
   endfunction

   task automatic model_reset();
      m_cnt = 0;
      m_idx = 0;
      o_cnt = 0;
      o_idx = 0;
      for (int i = 0; i < ND; i++) m_dig[i] = 4'd0;
      m_dp    = '0;
      m_blank = '0;
      sb_q.delete();
   endtask

   task automatic tick();
      exp_t e;
      exp_t g;
      logic lit;
      logic [ND-1:0] lz;
      bit seen;
      e.fs  = en && (m_cnt == 0) && (m_idx == 0);
      lit   = en && (m_cnt >= GD) && !m_blank[m_idx];
      e.an  = 4'hF;
      e.seg = 7'h7F;
      e.dp  = 1'b1;
      if (lit) begin
         e.an[m_idx] = 1'b0;
         e.seg       = tb_decode(m_dig[m_idx]);
         e.dp        = ~m_dp[m_idx];
      end
      sb_q.push_back(e);
      o_cnt = m_cnt;
      o_idx = m_idx;
      if (e.fs) begin
         seen = 1'b0;
         lz   = '0;
         for (int i = ND - 1; i >= 0; i--) begin
            m_dig[i] = digits_bcd[4*i +: 4];
            if (lz_blank && !seen && i != 0 && digits_bcd[4*i +: 4] == 4'd0) lz[i] = 1'b1;
            if (digits_bcd[4*i +: 4] != 4'd0) seen = 1'b1;
         end
         m_blank = blank_mask | lz;
         m_dp    = dp_mask;
      end
      if (!en) begin
         m_cnt = 0;
         m_idx = 0;
      end else if (m_cnt == DW - 1) begin
         m_cnt = 0;
         m_idx = (m_idx + 1) % ND;
      end else begin
         m_cnt++;
      end
      @(posedge clk);
      #1;
      g = sb_q.pop_front();
      check("sb_an",  32'(an),          32'(g.an));
      check("sb_seg", 32'(seg),         32'(g.seg));
      check("sb_dp",  32'(dp),          32'(g.dp));
      check("sb_fs",  32'(frame_start), 32'(g.fs));
   endtask

   // Advance until the current outputs were produced from slot s, count c.
   task automatic wait_slot(input int s, input int c);
      for (int k = 0; k < 200; k++) begin
         tick();
         if (o_idx == s && o_cnt == c) return;
      end
      check("wait_slot_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_out(input string tag, input logic [3:0] a, input logic [6:0] s, input logic d);
      check({tag, "_an"},  32'(an),  32'(a));
      check({tag, "_seg"}, 32'(seg), 32'(s));
      check({tag, "_dp"},  32'(dp),  32'(d));
   endtask

   initial begin
      bit lit_seen;
      rst_n      = 1'b0;
      en         = 1'b0;
      digits_bcd = '0;
      blank_mask = '0;
      dp_mask    = '0;
      lz_blank   = 1'b0;
      model_reset();

      #12;
      expect_out("reset", 4'hF, 7'b1111111, 1'b1);
      check("reset_fs", 32'(frame_start), 32'd0);

      @(negedge clk);
      rst_n      = 1'b1;
      en         = 1'b1;
      digits_bcd = 16'h1234;

      tick();
      check("first_fs", 32'(frame_start), 32'd1);
      expect_out("first_guard", 4'hF, 7'b1111111, 1'b1);
      wait_slot(0, 1);
      expect_out("s0_guard", 4'hF, 7'b1111111, 1'b1);
      wait_slot(0, 2);
      expect_out("s0_show", 4'b1110, 7'b1001100, 1'b1);
      wait_slot(1, 2);
      expect_out("s1_show", 4'b1101, 7'b0000110, 1'b1);

      digits_bcd = 16'h9999;
      wait_slot(2, 4);
      expect_out("tear_s2", 4'b1011, 7'b0010010, 1'b1);
      wait_slot(3, 4);
      expect_out("tear_s3", 4'b0111, 7'b1001111, 1'b1);
      wait_slot(0, 0);
      check("frame2_fs", 32'(frame_start), 32'd1);
      wait_slot(0, 3);
      expect_out("nine_s0", 4'b1110, 7'b0001100, 1'b1);
      wait_slot(3, 7);
      expect_out("nine_s3", 4'b0111, 7'b0001100, 1'b1);

      lz_blank   = 1'b1;
      digits_bcd = 16'h0050;
      wait_slot(0, 0);
      wait_slot(0, 4);
      expect_out("lz_s0", 4'b1110, 7'b0000001, 1'b1);
      wait_slot(1, 4);
      expect_out("lz_s1", 4'b1101, 7'b0100100, 1'b1);
      wait_slot(2, 4);
      expect_out("lz_s2", 4'hF, 7'b1111111, 1'b1);
      wait_slot(3, 4);
      expect_out("lz_s3", 4'hF, 7'b1111111, 1'b1);

      digits_bcd = 16'h0000;
      wait_slot(0, 0);
      wait_slot(0, 4);
      expect_out("zero_s0", 4'b1110, 7'b0000001, 1'b1);
      wait_slot(1, 4);
      expect_out("zero_s1", 4'hF, 7'b1111111, 1'b1);
      wait_slot(3, 4);
      expect_out("zero_s3", 4'hF, 7'b1111111, 1'b1);

      lz_blank   = 1'b0;
      digits_bcd = 16'h00A0;
      dp_mask    = 4'b0100;
      wait_slot(0, 0);
      wait_slot(0, 4);
      expect_out("dash_s0", 4'b1110, 7'b0000001, 1'b1);
      wait_slot(1, 4);
      expect_out("dash_s1", 4'b1101, 7'b1111110, 1'b1);
      wait_slot(2, 1);
      expect_out("dp_guard", 4'hF, 7'b1111111, 1'b1);
      wait_slot(2, 4);
      expect_out("dp_s2", 4'b1011, 7'b0000001, 1'b0);

      // Model now sits at slot 2, cnt 5: drop enable there.
      en = 1'b0;
      tick();
      expect_out("en_off", 4'hF, 7'b1111111, 1'b1);
      check("en_off_fs", 32'(frame_start), 32'd0);
      tick();
      tick();
      en = 1'b1;
      tick();
      check("en_on_fs", 32'(frame_start), 32'd1);
      expect_out("en_on", 4'hF, 7'b1111111, 1'b1);
      wait_slot(0, 1);
      expect_out("resume_guard", 4'hF, 7'b1111111, 1'b1);
      wait_slot(0, 2);
      expect_out("resume_show", 4'b1110, 7'b0000001, 1'b1);

      wait_slot(1, 4);
      expect_out("pre_rst", 4'b1101, 7'b1111110, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      expect_out("async_rst", 4'hF, 7'b1111111, 1'b1);
      check("async_rst_fs", 32'(frame_start), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      lit_seen = 1'b0;
      for (int k = 0; k < 20 && !lit_seen; k++) begin
         tick();
         if (an != 4'hF) lit_seen = 1'b1;
      end
      check("post_rst_lit_seen", 32'(lit_seen), 32'd1);
      expect_out("post_rst_first", 4'b1110, 7'b0000001, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
